hetic_irq_ctrl: RTL
===================

Name: hetic_irq_ctrl

Overview:
Core-side interrupt sequencer directly downstream of the interrupt controller. It takes the controller's arbitrated winner (valid/id/level/heti/nest) and filters it against the core threshold and the active handler level. It presents a registered request to the core, converts the core's acceptance into a one-cycle claim pulse back to the controller, and tracks nested handler levels on a bounded stack popped by mret.

Parameters:
NrIrqLines, 64, number of interrupt lines; IrqWidth = $clog2(NrIrqLines)
NrIrqPrios, 32, number of priority levels; PrioWidth = $clog2(NrIrqPrios)
StackDepth, 4, max saved preempted contexts (nesting depth), >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
irq_valid_i  in  1  controller winner valid
irq_id_i  in  IrqWidth  controller winner id
irq_level_i  in  PrioWidth  controller winner priority
irq_heti_i  in  1  winner is HETI (hardware-vectored)
irq_nest_i  in  1  winner's handler allows nesting
irq_ack_o  out  1  claim pulse to controller (clears ip)
irq_id_o  out  IrqWidth  id being claimed, valid with irq_ack_o
core_thresh_i  in  PrioWidth  core interrupt threshold
core_irq_req_o  out  1  request to core
core_irq_id_o  out  IrqWidth  requested id
core_irq_level_o  out  PrioWidth  requested level
core_irq_heti_o  out  1  requested is HETI
core_irq_ack_i  in  1  core accepts request this cycle
core_mret_i  in  1  core returns from a handler (1-cycle pulse)
cur_level_o  out  PrioWidth  active handler level (0 = none)
depth_o  out  $clog2(StackDepth+1)  number of stacked contexts
stack_err_o  out  1  sticky: mret with nothing active

Behaviour:
- Reset: all outputs 0, state IDLE, cur_level=0, cur_nest=1, depth=0, stack cleared.
- Active state: active = (cur_level != 0).
- Eligibility (comb): elig = irq_valid_i & irq_level_i > cur_level & irq_level_i > core_thresh_i & (!active | (cur_nest & depth < StackDepth)). All comparisons unsigned. Level 0 is never eligible.
- FSM states: IDLE, REQ, CLAIM.
- IDLE: if elig, register id/level/heti/nest into core_irq_* and go to REQ. core_irq_req_o is registered, so the request appears 1 cycle after elig.
- REQ: core_irq_req_o=1.
  - If core_irq_ack_i: push {cur_level,cur_nest}, load cur_level/cur_nest from the latched values, register irq_ack_o=1 with irq_id_o=latched id, go to CLAIM.
  - Else if elig: re-latch the current winner (retarget to a new id or level) and stay in REQ.
  - Else: drop core_irq_req_o next cycle and go to IDLE (withdraw).
  - Request-to-claim latency: ack cycle +1.
- CLAIM: irq_ack_o high exactly this cycle. No new request is latched (controller ip clears at the next edge). Always go to IDLE.
- core_mret_i (any state):
  - depth>0: pop into cur_level/cur_nest.
  - depth==0 and active: cur_level=0, cur_nest=1.
  - Not active: no change, stack_err_o set (cleared only by reset).
- Simultaneous mret and REQ ack: pop first, then push, so the stack is unchanged and cur = new latched. Eligibility for that ack was evaluated against the pre-pop level.
- Stack full (depth==StackDepth): no nested request. A pending REQ is withdrawn if elig drops.
- Reset mid-REQ or mid-CLAIM: everything returns to reset values immediately at the edge, and no irq_ack_o is issued.

Optional Feature:
HETIC_IRQ_CTRL_STATS_EN
- Defined: adds outputs taken_cnt_o[15:0] (claims), nest_cnt_o[15:0] (claims taken while active), withdraw_cnt_o[15:0] (REQ->IDLE without ack), and max_depth_o (max depth reached). Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- hetic_pkg: state enum, ctx_t struct {level[PrioWidth], nest}, width helper functions.
- Sub-module hetic_level_stack: parameterised LIFO of ctx_t with push/pop/same-cycle-replace, depth and full/empty outputs.

Test Plan:
- Basic take: valid id=5 level=3, thresh=0 -> req next cycle; ack -> irq_ack_o=1, irq_id_o=5 one cycle later; cur_level_o=3, depth_o=1.
- Threshold: level=3, thresh=3 -> no req. Raise level to 4 -> req with level 4.
- Nesting: active level 3 nest=1; id=9 level=7 arrives -> taken, depth=2. Second mret -> cur_level 3, then 0, depth 0.
- Nest disabled or stack full: active with nest=0, level 10 arrives -> no req. StackDepth=4 filled -> 5th higher irq ignored until mret.
- Retarget/withdraw: in REQ id=5 level=3, winner changes to id=8 level=6 -> core_irq_id_o=8 next cycle. Valid drops -> req falls, no irq_ack_o.
- Edge cases: mret with ack same cycle -> depth unchanged, cur=new level. mret when idle -> stack_err_o=1. rst_i during CLAIM -> no ack pulse, all zero.

Source files
------------

// File: rtl/hetic_pkg.sv
// Shared types and helpers for the core-side interrupt sequencer.
package hetic_pkg;

  // Saved contexts carry a fixed-width level so the stack type is config-independent.
  localparam int unsigned MaxPrioWidth = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLAIM = 2'd2
  } state_e;

  typedef struct packed {
    logic [MaxPrioWidth-1:0] level;
    logic                    nest;
  } ctx_t;

  localparam ctx_t CtxIdle = '{level: '0, nest: 1'b1};

  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hetic_level_stack.sv
// LIFO of preempted handler contexts; push+pop in one cycle replaces the top entry.
module hetic_level_stack
  import hetic_pkg::*;
#(
  parameter  int unsigned Depth  = 4,
  localparam int unsigned DepthW = clog2w(Depth + 1),
  localparam int unsigned IdxW   = clog2w(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  ctx_t              push_ctx,
  output ctx_t              top_ctx,
  output logic [DepthW-1:0] depth,
  output logic              full,
  output logic              empty
);

  ctx_t              mem [Depth];
  logic [IdxW-1:0]   top_idx;

  assign empty   = (depth == '0);
  assign full    = (depth == DepthW'(Depth));
  assign top_idx = empty ? '0 : IdxW'(depth - DepthW'(1));
  assign top_ctx = mem[top_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      mem[top_idx] <= push_ctx;
    end else if (push && !full) begin
      mem[IdxW'(depth)] <= push_ctx;
      depth             <= depth + DepthW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DepthW'(1);
    end
  end

endmodule

// File: rtl/hetic_irq_ctrl.sv
// Filters the controller's winner against threshold/active level, handshakes with the core,
// and tracks nested handlers. Define HETIC_IRQ_CTRL_STATS_EN to add claim/withdraw statistics.
module hetic_irq_ctrl
  import hetic_pkg::*;
#(
  parameter  int unsigned NrIrqLines = 64,
  parameter  int unsigned NrIrqPrios = 32,
  parameter  int unsigned StackDepth = 4,
  localparam int unsigned IrqWidth   = clog2w(NrIrqLines),
  localparam int unsigned PrioWidth  = clog2w(NrIrqPrios),
  localparam int unsigned DepthWidth = clog2w(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  irq_ack_o,
  output logic [IrqWidth-1:0]   irq_id_o,
  input  logic [PrioWidth-1:0]  core_thresh_i,
  output logic                  core_irq_req_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  output logic                  core_irq_heti_o,
  input  logic                  core_irq_ack_i,
  input  logic                  core_mret_i,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
`ifdef HETIC_IRQ_CTRL_STATS_EN
  output logic [15:0]           taken_cnt_o,
  output logic [15:0]           nest_cnt_o,
  output logic [15:0]           withdraw_cnt_o,
  output logic [DepthWidth-1:0] max_depth_o,
`endif
  output logic                  stack_err_o
);

  state_e state;
  ctx_t   cur_ctx, lat_ctx, top_ctx, post_ctx;
  logic   active, elig, take, pop_go, stk_full, stk_empty;

  assign active = (cur_ctx.level != '0);
  assign elig   = irq_valid_i
               && (MaxPrioWidth'(irq_level_i) > cur_ctx.level)
               && (irq_level_i > core_thresh_i)
               && (!active || (cur_ctx.nest && !stk_full));
  assign take   = (state == ST_REQ) && core_irq_ack_i;
  assign pop_go = core_mret_i && !stk_empty;

  // Context after mret alone; an accepting core pushes this and then overwrites cur.
  always_comb begin
    post_ctx = cur_ctx;
    if (pop_go)                      post_ctx = top_ctx;
    else if (core_mret_i && active)  post_ctx = CtxIdle;
  end

  hetic_level_stack #(.Depth(StackDepth)) u_stack (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (take),
    .pop      (pop_go),
    .push_ctx (post_ctx),
    .top_ctx  (top_ctx),
    .depth    (depth_o),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign core_irq_level_o = lat_ctx.level[PrioWidth-1:0];
  assign cur_level_o      = cur_ctx.level[PrioWidth-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      core_irq_req_o  <= 1'b0;
      core_irq_id_o   <= '0;
      core_irq_heti_o <= 1'b0;
      lat_ctx         <= '0;
      irq_ack_o       <= 1'b0;
      irq_id_o        <= '0;
      cur_ctx         <= CtxIdle;
      stack_err_o     <= 1'b0;
    end else begin
      irq_ack_o <= 1'b0;
      cur_ctx   <= post_ctx;
      if (core_mret_i && !active) stack_err_o <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (elig) begin
            core_irq_id_o   <= irq_id_i;
            core_irq_heti_o <= irq_heti_i;
            lat_ctx         <= '{level: MaxPrioWidth'(irq_level_i), nest: irq_nest_i};
            core_irq_req_o  <= 1'b1;
            state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (core_irq_ack_i) begin
            cur_ctx        <= lat_ctx;
            irq_ack_o      <= 1'b1;
            irq_id_o       <= core_irq_id_o;
            core_irq_req_o <= 1'b0;
            state          <= ST_CLAIM;
          end else if (elig) begin
            core_irq_id_o   <= irq_id_i;
            core_irq_heti_o <= irq_heti_i;
            lat_ctx         <= '{level: MaxPrioWidth'(irq_level_i), nest: irq_nest_i};
          end else begin
            core_irq_req_o <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        // The controller's pending bit clears at this edge, so nothing is latched here.
        ST_CLAIM: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef HETIC_IRQ_CTRL_STATS_EN
  logic withdraw;
  assign withdraw = (state == ST_REQ) && !core_irq_ack_i && !elig;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_o    <= '0;
      nest_cnt_o     <= '0;
      withdraw_cnt_o <= '0;
      max_depth_o    <= '0;
    end else begin
      if (take)           taken_cnt_o    <= sat_inc16(taken_cnt_o);
      if (take && active) nest_cnt_o     <= sat_inc16(nest_cnt_o);
      if (withdraw)       withdraw_cnt_o <= sat_inc16(withdraw_cnt_o);
      if (depth_o > max_depth_o) max_depth_o <= depth_o;
    end
  end
`endif

endmodule
